// File: rtl/draw_pair_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : draw_pair_scheduler
//  Description : Round-robin scheduler for the draw-path address-pair
//                generator. Two requesters each ask for a run of LEN
//                consecutive pair indices starting at BASE. The winner is
//                granted for the whole run, and one even/odd address pair
//                ({idx,0},{idx,1}) is emitted per accepted beat toward the
//                dual-port frame memory. A one-cycle done pulse closes
//                the run.
//
//  Ports       : clk            system clock, rising edge
//                reset          asynchronous active-high reset
//                req[1:0]       per-requester run request (level)
//                base0/base1    starting pair index per requester
//                len0/len1      pair count per requester
//                gnt[1:0]       one-hot grant, held for the owned run
//                pair_valid     addr_a/addr_b carry a valid pair
//                pair_ready     memory accepts the pair this cycle
//                addr_a         even address {idx,1'b0}
//                addr_b         odd address  {idx,1'b1}
//                done[1:0]      one-cycle completion pulse to the owner
//                busy           scheduler is not idle
//
//  Revision    : 1.0  initial release
// ============================================================================
module draw_pair_scheduler #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [ADDR_W-2:0] base0,
    input  logic [LEN_W-1:0]  len0,
    input  logic [ADDR_W-2:0] base1,
    input  logic [LEN_W-1:0]  len1,
    output logic [1:0]        gnt,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [1:0]        done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-2:0] c_IDX_ONE = {{(ADDR_W-2){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  c_LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [ADDR_W-2:0]  r_idx;
    logic [LEN_W-1:0]   r_remaining;
    logic [1:0]         r_gnt;
    logic               r_ptr;      // 0: requester 0 favoured on a tie

    state_t             w_state_nxt;
    logic [ADDR_W-2:0]  w_idx_nxt;
    logic [LEN_W-1:0]   w_remaining_nxt;
    logic [1:0]         w_gnt_nxt;
    logic               w_ptr_nxt;

    logic               w_sel;      // winning requester index
    logic [ADDR_W-2:0]  w_sel_base;
    logic [LEN_W-1:0]   w_sel_len;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_remaining <= '0;
            r_gnt       <= 2'b00;
            r_ptr       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_remaining <= w_remaining_nxt;
            r_gnt       <= w_gnt_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_remaining_nxt = r_remaining;
        w_gnt_nxt       = r_gnt;
        w_ptr_nxt       = r_ptr;

        // A tie is broken by the pointer; a single request wins outright.
        w_sel      = (req == 2'b11) ? r_ptr : req[1];
        w_sel_base = w_sel ? base1 : base0;
        w_sel_len  = w_sel ? len1  : len0;

        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_idx_nxt       = w_sel_base;
                    w_remaining_nxt = w_sel_len;
                    w_gnt_nxt       = w_sel ? 2'b10 : 2'b01;
                    // A zero-length run skips RUN so remaining never underflows.
                    w_state_nxt     = (w_sel_len == '0) ? S_FIN : S_RUN;
                end
            end

            S_RUN: begin
                // pair_valid is constant-high here, so a beat is pair_ready.
                if (pair_ready) begin
                    w_idx_nxt       = r_idx + c_IDX_ONE;   // wraps silently
                    w_remaining_nxt = r_remaining - c_LEN_ONE;
                    if (r_remaining == c_LEN_ONE) begin
                        w_state_nxt = S_FIN;
                    end
                end
            end

            S_FIN: begin
                // Favour the other requester next time.
                w_ptr_nxt   = ~r_gnt[1];
                w_gnt_nxt   = 2'b00;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_gnt_nxt   = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // ------------------------------------------------------------------
    assign gnt        = r_gnt;
    assign pair_valid = (r_state == S_RUN);
    assign addr_a     = {r_idx, 1'b0};
    assign addr_b     = {r_idx, 1'b1};
    assign done       = (r_state == S_FIN) ? r_gnt : 2'b00;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_draw_pair_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_pair_scheduler
//  Description : Directed self-checking bench for draw_pair_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_draw_pair_scheduler;

    localparam int ADDR_W = 14;
    localparam int LEN_W  = 8;
    localparam int IDX_MOD = 1 << (ADDR_W - 1);

    logic              clk;
    logic              reset;
    logic [1:0]        req;
    logic [ADDR_W-2:0] base0;
    logic [LEN_W-1:0]  len0;
    logic [ADDR_W-2:0] base1;
    logic [LEN_W-1:0]  len1;
    logic [1:0]        gnt;
    logic              pair_valid;
    logic              pair_ready;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [1:0]        done;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    draw_pair_scheduler #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .base0      (base0),
        .len0       (len0),
        .base1      (base1),
        .len1       (len1),
        .gnt        (gnt),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset_vals(input string tag);
        chk({tag, " gnt"},        32'(gnt),        32'd0);
        chk({tag, " pair_valid"}, 32'(pair_valid), 32'd0);
        chk({tag, " done"},       32'(done),       32'd0);
        chk({tag, " busy"},       32'(busy),       32'd0);
        chk({tag, " addr_a"},     32'(addr_a),     32'd0);
        chk({tag, " addr_b"},     32'(addr_b),     32'd1);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, " idle gnt"},  32'(gnt),        32'd0);
        chk({tag, " idle pv"},   32'(pair_valid), 32'd0);
        chk({tag, " idle done"}, 32'(done),       32'd0);
        chk({tag, " idle busy"}, 32'(busy),       32'd0);
    endtask

    // Check n consecutive beats with pair_ready high, starting at index base.
    task automatic run_beats(input string tag, input int base, input int n, input logic [1:0] owner);
        int exp_idx;
        for (int i = 0; i < n; i++) begin
            exp_idx = (base + i) % IDX_MOD;
            chk({tag, " pv"},     32'(pair_valid), 32'd1);
            chk({tag, " gnt"},    32'(gnt),        32'(owner));
            chk({tag, " done"},   32'(done),       32'd0);
            chk({tag, " addr_a"}, 32'(addr_a),     32'(exp_idx * 2));
            chk({tag, " addr_b"}, 32'(addr_b),     32'(exp_idx * 2 + 1));
            step();
        end
    endtask

    task automatic expect_fin(input string tag, input logic [1:0] owner);
        chk({tag, " fin done"}, 32'(done),       32'(owner));
        chk({tag, " fin gnt"},  32'(gnt),        32'(owner));
        chk({tag, " fin pv"},   32'(pair_valid), 32'd0);
        chk({tag, " fin busy"}, 32'(busy),       32'd1);
    endtask

    initial begin
        int          beats;
        int          cyc;
        logic [15:0] rdy_pat;

        reset      = 1'b1;
        req        = 2'b00;
        base0      = '0;
        len0       = '0;
        base1      = '0;
        len1       = '0;
        pair_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        expect_reset_vals("reset");
        reset = 1'b0;
        step();
        expect_idle("post-reset");

        // ---------------- single 128-pair run from 1024 ----------------
        req   = 2'b01;
        base0 = 13'd1024;
        len0  = 8'd128;
        step();
        run_beats("run128", 1024, 128, 2'b01);
        expect_fin("run128", 2'b01);
        req = 2'b00;
        step();
        expect_idle("run128");

        // ---------------- round-robin, both held high ----------------
        // Fresh reset so the pointer favours requester 0 again.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        chk("rr pre gnt", 32'(gnt), 32'd0);
        req   = 2'b11;
        base0 = 13'd0;
        len0  = 8'd2;
        base1 = 13'd100;
        len1  = 8'd2;
        step();
        for (int k = 0; k < 4; k++) begin
            run_beats("rr", (k % 2 == 0) ? 0 : 100, 2, (k % 2 == 0) ? 2'b01 : 2'b10);
            expect_fin("rr", (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 3) req = 2'b00;
            step();
            expect_idle("rr gap");
            if (k < 3) step();
        end

        // ---------------- stalls: pair_ready 1,0,0,1,1,1... ----------------
        req     = 2'b01;
        base0   = 13'd50;
        len0    = 8'd4;
        rdy_pat = 16'hFFF9;
        beats   = 0;
        cyc     = 0;
        step();
        while (pair_valid && cyc < 16) begin
            pair_ready = rdy_pat[cyc];
            chk("stall addr_a", 32'(addr_a), 32'((50 + beats) * 2));
            chk("stall addr_b", 32'(addr_b), 32'((50 + beats) * 2 + 1));
            if (pair_ready) beats++;
            cyc++;
            step();
        end
        chk("stall beats", 32'(beats), 32'd4);
        chk("stall cycles", 32'(cyc), 32'd6);
        expect_fin("stall", 2'b01);
        pair_ready = 1'b1;
        req        = 2'b00;
        step();
        expect_idle("stall");

        // ---------------- zero-length run on requester 1 ----------------
        req   = 2'b10;
        base1 = 13'd7;
        len1  = 8'd0;
        #1;
        chk("len0 pre pv", 32'(pair_valid), 32'd0);
        step();
        expect_fin("len0", 2'b10);
        req = 2'b00;
        step();
        expect_idle("len0");

        // ---------------- index wrap at 2^13-1 ----------------
        req   = 2'b01;
        base0 = 13'd8191;
        len0  = 8'd2;
        step();
        run_beats("wrap", 8191, 2, 2'b01);
        expect_fin("wrap", 2'b01);
        req = 2'b00;
        step();
        expect_idle("wrap");

        // ---------------- reset mid-run, then restart ----------------
        req   = 2'b01;
        base0 = 13'd300;
        len0  = 8'd10;
        step();
        run_beats("abort", 300, 5, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        expect_reset_vals("abort");
        step();
        chk("abort held done", 32'(done), 32'd0);
        chk("abort held gnt",  32'(gnt),  32'd0);
        reset = 1'b0;
        step();
        run_beats("restart", 300, 10, 2'b01);
        expect_fin("restart", 2'b01);
        req = 2'b00;
        step();
        expect_idle("restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_pair_scheduler.md
Name: draw_pair_scheduler

Overview:
- Sequences the draw-path address-pair generator, shared between two requesters (e.g. clear engine and line renderer).
- Each requester asks for a run of N consecutive pair indices starting at a base. The block arbitrates round-robin and emits one even/odd address pair per accepted beat (addr_a = {idx,0}, addr_b = {idx,1}) toward the dual-port frame memory.
- Signals completion to the granted requester.

Parameters:
- ADDR_W, 14, width of the emitted addresses; pair index width is ADDR_W-1.
- LEN_W, 8, width of the run-length (pair count) inputs.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-requester run request, level; held until that requester's done.
- base0  in  ADDR_W-1  requester 0 starting pair index.
- len0  in  LEN_W  requester 0 pair count.
- base1  in  ADDR_W-1  requester 1 starting pair index.
- len1  in  LEN_W  requester 1 pair count.
- gnt  out  2  one-hot grant, high for the whole owned run.
- pair_valid  out  1  addr_a/addr_b hold a valid pair.
- pair_ready  in  1  memory accepts the pair this cycle.
- addr_a  out  ADDR_W  even address {idx,1'b0}.
- addr_b  out  ADDR_W  odd address {idx,1'b1}.
- done  out  2  one-cycle completion pulse to the owning requester.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, any state): state=IDLE; gnt=0, done=0, pair_valid=0, busy=0; idx=0, remaining=0; addr_a=0, addr_b=1 (from idx=0); priority pointer=0 (requester 0 favoured). Any run in progress is aborted with no done.
- States: IDLE, RUN, FIN.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req bit set: select that requester.
  - Both set: select the requester named by the priority pointer.
  - On selection: latch base/len of the winner into idx/remaining, set gnt one-hot.
  - Latched len != 0: go to RUN. Latched len == 0: go to FIN.
  - Latency: req high at edge n gives gnt and pair_valid high after edge n+1 (registered).
- RUN:
  - pair_valid=1; addr_a/addr_b are driven from registered idx.
  - Beat occurs when pair_valid && pair_ready. On a beat: idx <= idx+1 (mod 2^(ADDR_W-1), wraps silently), remaining <= remaining-1.
  - Beat with remaining==1: go to FIN, pair_valid drops the next cycle.
  - Without a beat, addr_a/addr_b and remaining hold stable (valid must not retract).
- FIN:
  - done[owner]=1 for exactly one cycle; gnt still asserted this cycle; pair_valid=0.
  - Priority pointer <= ~owner.
  - Next state IDLE with gnt cleared.
- A requester must see done before deasserting req. A req drop during RUN is ignored and the run completes; a req still high in IDLE after done is treated as a new request.
- Back-to-back: both requesters held high alternate 0,1,0,1. A minimum of one IDLE cycle separates runs.
- Max run: len = 2^LEN_W-1 pairs. remaining is LEN_W bits wide; there is no underflow because RUN is entered only with a nonzero count.
- Throughput: with pair_ready tied high, one pair per cycle. A run of N pairs occupies 1 IDLE + N RUN + 1 FIN cycles.
- busy = (state != IDLE).

Test Plan:
- Reset, then req=01, base0=1024, len0=128, pair_ready=1 -> gnt=01. Pairs (2048,2049) through (2302,2303), exactly 128 beats. done=01 one cycle after the last beat. Return to IDLE.
- req=11 held continuously, len0=len1=2, base0=0, base1=100 -> grant order 0,1,0,1. Addresses (0,1),(2,3) then (200,201),(202,203). done pulses alternate.
- pair_ready toggled 1,0,0,1 mid-run -> addr_a/addr_b frozen during stalls, no skipped or duplicated indices, beat count equals len.
- len1=0, req=10 -> gnt=10, no pair_valid, done=10 two cycles after req.
- base0=2^13-1 (8191), len0=2 -> pairs (16382,16383) then (0,1) (wrap). done asserted.
- Assert reset mid-run after 5 beats -> outputs return to reset values immediately, no done. The same request reissued restarts from base.
